imuldiv_three_mul_resp_serializer: RTL
======================================

Name: imuldiv_three_mul_resp_serializer

Overview:
Downstream stage of the three-input multiplier. It consumes the 96-bit signed product response over val/rdy and emits it as three 32-bit words over a narrow val/rdy stream for writeback to a 32-bit register file or bus. It holds one response internally. It sustains full throughput: one word per cycle, with the next response accepted in the same cycle the final word of the current one leaves.

Parameters:
DATA_W, 32, width of each output word
NWORDS, 3, words per response; DATA_W*NWORDS must equal the response message size (96)
LSW_FIRST, 1, 1 = emit word 0 (bits 31:0) first; 0 = emit word NWORDS-1 (most significant) first

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
muldivresp_msg_result  input  96  signed product from the multiplier
muldivresp_val  input  1  response valid
muldivresp_rdy  output  1  serializer can accept a response
out_msg_data  output  32  current word
out_msg_idx  output  2  index of current word within the 96-bit result (0 = bits 31:0)
out_msg_last  output  1  current word is the final word of the response
out_val  output  1  output word valid
out_rdy  input  1  consumer ready

Behaviour:
- Single clock clk. Reset is synchronous and active-high; all state is cleared on the clk edge while reset = 1.
- State machine: IDLE, SEND0, SEND1, SEND2 (SENDk = k-th emitted word). Reset -> IDLE.
- Outputs during reset and in IDLE: out_val=0, out_msg_data=0, out_msg_idx=0, out_msg_last=0.
- muldivresp_rdy = !reset && (state==IDLE || (state==SEND2 && out_rdy)). This is combinational; the bypass is what gives zero-bubble throughput.
- Accept: muldivresp_val && muldivresp_rdy latches the result into a 96-bit holding register. Next state is SEND0.
- Latency: the first word appears (out_val=1) on the cycle after acceptance. There is no combinational path from muldivresp_msg_result to out_msg_data.
- In SENDk, word index w is k if LSW_FIRST=1, otherwise NWORDS-1-k.
  - out_msg_data = held[32w+31:32w]
  - out_msg_idx = w
  - out_msg_last = (k==2)
  - out_val = 1
- Advance: out_val && out_rdy fires the word.
  - SEND0 -> SEND1, SEND1 -> SEND2.
  - SEND2 -> SEND0 if a new response is accepted in the same cycle (holding register reloaded); otherwise SEND2 -> IDLE.
- Backpressure: while out_val && !out_rdy, state and all out_msg_* hold stable (val/rdy stability rule). muldivresp_rdy stays 0 except in SEND2 with out_rdy=1.
- Simultaneous events: in SEND2 with out_rdy=1 and muldivresp_val=1, the last word fires and the new response loads in the same edge. The next cycle shows word 0 of the new response.
- Reset mid-operation: the held response is discarded with no partial completion. IDLE and out_val=0 on the cycle after the reset edge.
- The result is passed bit-exact; sign is carried only in the upper word. The block does no arithmetic.
- Throughput: N back-to-back responses with out_rdy held high produce 3N words in 3N consecutive cycles after the first-word latency.

Decomposition:
- Shared message header alongside the existing response message definitions:
  - response size 96
  - word size 32
  - word count 3
  - index width 2
  - state encodings IMULDIV_SER_IDLE/SEND0/SEND1/SEND2
- Natural split into a control sub-module imuldiv_three_mul_resp_serializer_ctrl (FSM, rdy/val, last/idx). The datapath (holding register plus 3:1 word mux) stays in the top module.

Test Plan:
- Single response 96'hffffffffc000000080000000, out_rdy=1, LSW_FIRST=1 -> words 80000000/idx0, c0000000/idx1, ffffffff/idx2/last=1 on three consecutive cycles starting the cycle after acceptance; then out_val=0.
- Back-to-back 96'h000000003fffffff00000001 then 96'h000000004000000000000000, src val always 1, out_rdy=1 -> 00000001, 3fffffff, 00000000, 00000000, 40000000, 00000000 in 6 consecutive cycles. muldivresp_rdy is high only in IDLE and on each SEND2 cycle.
- Backpressure: 96'h000000000000000013ae3fe6 with out_rdy=0 for 4 cycles while word idx1 is presented -> out_msg_data=00000000, idx=1 held stable all 4 cycles, muldivresp_rdy=0. Completes normally once out_rdy=1.
- LSW_FIRST=0, 96'hffffffffc000000080000000 -> ffffffff/idx2, c0000000/idx1, 80000000/idx0/last=1.
- Reset asserted during SEND1 of 96'h000000000000000016414511 -> out_val=0 the next cycle, no further words. A following response 96'h000000000000000000000005 emits 00000005, 00000000, 00000000 cleanly.
- Idle: muldivresp_val=0 for 20 cycles after reset -> out_val=0 throughout, muldivresp_rdy=1.

Source files
------------

// File: rtl/imuldiv_three_mul_resp_serializer_pkg.sv
// imuldiv_three_mul_resp_serializer_pkg: shared sizes and serializer state encodings
package imuldiv_three_mul_resp_serializer_pkg;
   localparam int RESP_W    = 96;
   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 3;
   localparam int IDX_W     = 2;
   typedef enum logic [1:0] {
      IMULDIV_SER_IDLE  = 2'd0,
      IMULDIV_SER_SEND0 = 2'd1,
      IMULDIV_SER_SEND1 = 2'd2,
      IMULDIV_SER_SEND2 = 2'd3
   } ser_state_e;
endpackage

// File: rtl/imuldiv_three_mul_resp_serializer_ctrl.sv
// imuldiv_three_mul_resp_serializer_ctrl: word-sequencing FSM with val/rdy handshakes and idx/last
module imuldiv_three_mul_resp_serializer_ctrl
   import imuldiv_three_mul_resp_serializer_pkg::*;
#(
   parameter bit LSW_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             resp_val,
   input  logic             out_rdy,
   output logic             resp_rdy,
   output logic             load,
   output logic             out_val,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last
);
   ser_state_e       state, nxt;
   logic             fire;
   logic [IDX_W-1:0] k;
   always_ff @(posedge clk) begin
      if (reset) state <= IMULDIV_SER_IDLE;
      else       state <= nxt;
   end
   // Accepting while the last word leaves is what keeps the stream bubble-free.
   always_comb begin
      resp_rdy = !reset && (state == IMULDIV_SER_IDLE || (state == IMULDIV_SER_SEND2 && out_rdy));
      load     = resp_val && resp_rdy;
      out_val  = !reset && state != IMULDIV_SER_IDLE;
      fire     = out_val && out_rdy;
      k        = state == IMULDIV_SER_SEND0 ? 2'd0 : state == IMULDIV_SER_SEND1 ? 2'd1 : 2'd2;
      out_idx  = !out_val ? '0 : LSW_FIRST ? k : IDX_W'(NUM_WORDS - 1) - k;
      out_last = out_val && state == IMULDIV_SER_SEND2;
      nxt      = state == IMULDIV_SER_IDLE  ? (load ? IMULDIV_SER_SEND0 : IMULDIV_SER_IDLE) :
                 state == IMULDIV_SER_SEND0 ? (fire ? IMULDIV_SER_SEND1 : IMULDIV_SER_SEND0) :
                 state == IMULDIV_SER_SEND1 ? (fire ? IMULDIV_SER_SEND2 : IMULDIV_SER_SEND1) :
                 load ? IMULDIV_SER_SEND0 : fire ? IMULDIV_SER_IDLE : IMULDIV_SER_SEND2;
   end
endmodule

// File: rtl/imuldiv_three_mul_resp_serializer.sv
// imuldiv_three_mul_resp_serializer: splits a 96-bit product response into three 32-bit val/rdy words
module imuldiv_three_mul_resp_serializer
   import imuldiv_three_mul_resp_serializer_pkg::*;
#(
   parameter int DATA_W    = WORD_W,
   parameter int NWORDS    = NUM_WORDS,
   parameter bit LSW_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RESP_W-1:0] muldivresp_msg_result,
   input  logic              muldivresp_val,
   output logic              muldivresp_rdy,
   output logic [DATA_W-1:0] out_msg_data,
   output logic [IDX_W-1:0]  out_msg_idx,
   output logic              out_msg_last,
   output logic              out_val,
   input  logic              out_rdy
);
   logic [DATA_W*NWORDS-1:0] held;
   logic                     load;
   imuldiv_three_mul_resp_serializer_ctrl #(.LSW_FIRST(LSW_FIRST)) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .resp_val (muldivresp_val),
      .out_rdy  (out_rdy),
      .resp_rdy (muldivresp_rdy),
      .load     (load),
      .out_val  (out_val),
      .out_idx  (out_msg_idx),
      .out_last (out_msg_last)
   );
   always_ff @(posedge clk) begin
      if (reset)     held <= '0;
      else if (load) held <= muldivresp_msg_result;
   end
   // Words come only from the holding register, never straight from the input.
   always_comb begin
      out_msg_data = !out_val ? '0 :
                     out_msg_idx == 2'd0 ? held[DATA_W-1:0] :
                     out_msg_idx == 2'd1 ? held[2*DATA_W-1:DATA_W] : held[3*DATA_W-1:2*DATA_W];
   end
endmodule
